// File: rtl/div14_seq_pkg.sv
// Shared constants, state encoding and helpers for the div14_seq restoring divider.
package div14_seq_pkg;

   localparam int unsigned DIV14_WIDTH = 14;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   // A new request may only be taken while no iteration is in flight.
   function automatic logic accepts_start(input div_state_e s);
      return (s == S_IDLE) || (s == S_DONE);
   endfunction

endpackage

// File: rtl/div14_seq_if.sv
// Request/result bundle between the calculator control FSM (master) and the divider (slave).
// div_err is only present when DIV14_ERR_EN is defined.
interface div14_seq_if
   import div14_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DIV14_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
`ifdef DIV14_ERR_EN
   logic             div_err;
`endif

   modport master (
`ifdef DIV14_ERR_EN
      input  div_err,
`endif
      output start,
      output dividend,
      output divisor,
      input  busy,
      input  done,
      input  quotient,
      input  remainder
   );

   modport slave (
`ifdef DIV14_ERR_EN
      output div_err,
`endif
      input  start,
      input  dividend,
      input  divisor,
      output busy,
      output done,
      output quotient,
      output remainder
   );

endinterface

// File: rtl/div14_seq_sub15_borrow.sv
// Combinational W-bit subtractor returning the difference and the borrow out.
module sub15_borrow #(
   parameter int unsigned W = 15
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div14_seq.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle, start/done handshake.
// Optional feature macro DIV14_ERR_EN: zero divisor short-circuits to DONE and raises div_err.
module div14_seq
   import div14_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DIV14_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   div14_seq_if.slave bus
);

   localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV14_ERR_EN
   logic             err_pend_q, err_pend_d;
   logic             div_err_q, div_err_d;
`endif

   logic [WIDTH:0]   r_shift_c;
   logic [WIDTH:0]   trial_c;
   logic             borrow_c;
   logic             unused_trial_msb;

   // Partial remainder stays below the divisor, so it fits WIDTH bits; only the shifted value needs WIDTH+1.
   assign r_shift_c        = {rem_q, quo_q[WIDTH-1]};
   assign unused_trial_msb = trial_c[WIDTH];

   sub15_borrow #(
      .W (WIDTH + 1)
   ) u_trial_sub (
      .a      (r_shift_c),
      .b      ({1'b0, dvs_q}),
      .diff   (trial_c),
      .borrow (borrow_c)
   );

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef DIV14_ERR_EN
      err_pend_d  = err_pend_q;
      div_err_d   = div_err_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accepts_start(state_q) && bus.start) begin
               state_d = S_RUN;
               rem_d   = '0;
               quo_d   = bus.dividend;
               dvs_d   = bus.divisor;
               count_d = '0;
               busy_d  = 1'b1;
`ifdef DIV14_ERR_EN
               err_pend_d = 1'b0;
               div_err_d  = 1'b0;
               // Zero divisor: preload the final answer and jump straight to the publish step.
               if (bus.divisor == '0) begin
                  rem_d      = bus.dividend;
                  quo_d      = '1;
                  count_d    = CNT_LAST;
                  busy_d     = 1'b0;
                  err_pend_d = 1'b1;
               end
`endif
            end
         end

         S_RUN: begin
            // Once all WIDTH steps are in, the next edge publishes the result.
            if (count_q == CNT_LAST) begin
               state_d     = S_DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               quotient_d  = quo_q;
               remainder_d = rem_q;
`ifdef DIV14_ERR_EN
               div_err_d   = err_pend_q;
`endif
            end else begin
               if (borrow_c) begin
                  rem_d = r_shift_c[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end else begin
                  rem_d = trial_c[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end
               count_d = count_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIV14_ERR_EN
         err_pend_q  <= 1'b0;
         div_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
`ifdef DIV14_ERR_EN
         err_pend_q  <= err_pend_d;
         div_err_q   <= div_err_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
`ifdef DIV14_ERR_EN
   assign bus.div_err   = div_err_q;
`endif

endmodule

// File: tb/tb_div14_seq.sv
// Directed and randomized checks of div14_seq against plain / and % arithmetic.
module tb_div14_seq;
   import div14_seq_pkg::*;

   localparam int unsigned   W    = DIV14_WIDTH;
   localparam logic [W-1:0] ALL1 = '1;
`ifdef DIV14_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   div14_seq_if bus ();

   div14_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one request (optionally poking start mid-run) and check the handshake and results.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb,
                        input logic [W-1:0] da, input logic [W-1:0] db,
                        output logic [W-1:0] eq, output logic [W-1:0] er);
      int lat;
      int elapsed;
      int busy_bad;
      bit eb;
      if (b == '0) begin
         eq  = ALL1;
         er  = a;
         lat = ERR_EN ? 1 : int'(W) + 1;
      end else begin
         eq  = W'(a / b);
         er  = W'(a % b);
         lat = int'(W) + 1;
      end
      eb           = (lat > 1);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      elapsed   = 0;
      busy_bad  = 0;
      while (bus.done !== 1'b1 && elapsed < 40) begin
         if (bus.busy !== eb) busy_bad++;
         if (disturb && elapsed == 3) begin
            bus.start    = 1'b1;
            bus.dividend = da;
            bus.divisor  = db;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         elapsed++;
      end
      bus.start = 1'b0;
      check("latency", 32'(elapsed), 32'(lat));
      check("busy_while_running", 32'(busy_bad), 32'd0);
      check("busy_at_done", 32'(bus.busy), 32'd0);
      check("quotient", 32'(bus.quotient), 32'(eq));
      check("remainder", 32'(bus.remainder), 32'(er));
`ifdef DIV14_ERR_EN
      check("div_err", 32'(bus.div_err), 32'(b == '0));
`endif
   endtask

   initial begin
      logic [W-1:0] eq, er, a, b;
      int           sel;
      int           dones;

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_quotient", 32'(bus.quotient), 32'd0);
      check("rst_remainder", 32'(bus.remainder), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed operand patterns and boundaries.
      do_op(14'd9999, 14'd7, 1'b0, '0, '0, eq, er);
      do_op(14'd16383, 14'd1, 1'b0, '0, '0, eq, er);
      do_op(14'd100, 14'd100, 1'b0, '0, '0, eq, er);
      do_op(14'd5, 14'd9, 1'b0, '0, '0, eq, er);
      do_op(14'd0, 14'd37, 1'b0, '0, '0, eq, er);

      // start during RUN is ignored; start in the done cycle runs back-to-back.
      do_op(14'd9999, 14'd7, 1'b1, 14'd50, 14'd3, eq, er);
      do_op(14'd50, 14'd3, 1'b0, '0, '0, eq, er);
      @(posedge clk); #1;
      check("done_single_cycle", 32'(bus.done), 32'd0);

      // Zero divisor.
      do_op(14'd1234, 14'd0, 1'b0, '0, '0, eq, er);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a run.
      bus.start    = 1'b1;
      bus.dividend = 14'd1000;
      bus.divisor  = 14'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_quotient", 32'(bus.quotient), 32'd0);
      check("abort_remainder", 32'(bus.remainder), 32'd0);
      @(posedge clk); #1;
      rst   = 1'b0;
      dones = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      check("abort_idle_busy", 32'(bus.busy), 32'd0);
      do_op(14'd81, 14'd9, 1'b0, '0, '0, eq, er);
      @(posedge clk); #1;

      // Randomized operands against the arithmetic reference.
      for (int i = 0; i < 1000; i++) begin
         a   = W'($urandom_range(0, 16383));
         sel = $urandom_range(0, 9);
         if (sel == 0)      b = '0;
         else if (sel <= 3) b = W'($urandom_range(1, 15));
         else if (sel == 4) b = a;
         else               b = W'($urandom_range(1, 16383));
         do_op(a, b, ($urandom_range(0, 4) == 0), W'($urandom), W'($urandom), eq, er);
         if ($urandom_range(0, 3) != 0) begin
            @(posedge clk); #1;
            check("done_pulse", 32'(bus.done), 32'd0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check("hold_quotient", 32'(bus.quotient), 32'(eq));
            check("hold_remainder", 32'(bus.remainder), 32'(er));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
